// File: rtl/mem_handshake_if.sv
// Request/response bus between a request master and the mem_handshake scratch-pad.
// The master drives the request fields; the memory returns read data and readiness.
interface mem_handshake_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  wr_rd_en_i;
  logic                  valid_i;
  logic                  ready_o;

  modport master (
    output addr_i,
    output wdata_i,
    output wr_rd_en_i,
    output valid_i,
    input  rdata_o,
    input  ready_o
  );

  modport slave (
    input  addr_i,
    input  wdata_i,
    input  wr_rd_en_i,
    input  valid_i,
    output rdata_o,
    output ready_o
  );
endinterface

// File: rtl/mem_handshake.sv
// Single-port DEPTH x WIDTH scratch-pad memory behind a valid/ready handshake.
// One request (write or read) is accepted per cycle once ready is up.
// Read data is registered and appears one cycle after acceptance.
// Reset is synchronous and active-low and clears every location.
module mem_handshake #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_handshake_if.slave bus
);

  // DEPTH expressed with one extra bit so addresses can be range-checked
  // without the comparison truncating.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             ready_q;
  logic             ready_d;

  logic             accept_s;
  logic             in_range_s;

  // Handshake decode and next-state of storage, read data and readiness.
  always_comb begin
    accept_s   = bus.valid_i & ready_q;
    in_range_s = ({1'b0, bus.addr_i} < DEPTH_L);
    mem_d      = mem_q;
    rdata_d    = rdata_q;
    // Readiness only drops while in reset; the reset branch of the
    // register overrides this.
    ready_d    = 1'b1;
    if (accept_s) begin
      if (bus.wr_rd_en_i) begin
        // Writes to addresses beyond DEPTH are silently dropped.
        if (in_range_s) begin
          mem_d[bus.addr_i] = bus.wdata_i;
        end else begin
          mem_d = mem_q;
        end
        rdata_d = rdata_q;
      end else begin
        // Reads beyond DEPTH complete the handshake and return zero.
        if (in_range_s) begin
          rdata_d = mem_q[bus.addr_i];
        end else begin
          rdata_d = '0;
        end
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers; reset clears the whole array, read data and readiness.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_mem_handshake.sv
// Self-checking bench for mem_handshake: directed scenarios followed by
// randomized traffic, all compared against a behavioural memory model.
module tb_mem_handshake;

  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk;
  logic rst_n;

  mem_handshake_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus_if ();

  mem_handshake #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: what the memory holds, what rdata_o shows,
  // and whether the memory is currently able to accept.
  logic [WIDTH-1:0] exp_mem [DEPTH];
  logic [WIDTH-1:0] exp_rdata;
  logic             exp_ready;

  int n_checks;
  int n_errors;

  // Single comparison point for every check in the bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check.
  task automatic step(input string tag, input logic rst, input logic v, input logic wr,
                      input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    rst_n             = rst;
    bus_if.valid_i    = v;
    bus_if.wr_rd_en_i = wr;
    bus_if.addr_i     = a;
    bus_if.wdata_i    = d;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_rdata = '0;
      exp_ready = 1'b0;
    end else begin
      if (v && exp_ready) begin
        if (wr) exp_mem[a] = d;
        else    exp_rdata  = exp_mem[a];
      end
      exp_ready = 1'b1;
    end
    #1;
    check_eq({tag, "_rdata"}, {16'h0, bus_if.rdata_o}, {16'h0, exp_rdata});
    check_eq({tag, "_ready"}, {31'h0, bus_if.ready_o}, {31'h0, exp_ready});
  endtask

  // A valid write pulse that rises and falls between edges must be ignored.
  task automatic glitch_step(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus_if.valid_i    = 1'b1;
    bus_if.wr_rd_en_i = 1'b1;
    bus_if.addr_i     = a;
    bus_if.wdata_i    = d;
    #2;
    step("glitch", 1'b1, 1'b0, 1'b1, a, d);
  endtask

  // Bounded run time so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] sweep_data [DEPTH];
    n_checks          = 0;
    n_errors          = 0;
    exp_rdata         = '0;
    exp_ready         = 1'b0;
    rst_n             = 1'b0;
    bus_if.valid_i    = 1'b0;
    bus_if.wr_rd_en_i = 1'b0;
    bus_if.addr_i     = '0;
    bus_if.wdata_i    = '0;
    @(posedge clk);
    #1;

    // Reset for two cycles with a request pending: must be discarded.
    step("reset", 1'b0, 1'b1, 1'b1, 6'd2, 16'h1111);
    step("reset", 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
    // First released edge raises ready; a write on that edge is not accepted.
    step("release", 1'b1, 1'b1, 1'b1, 6'd2, 16'h5555);
    check_eq("release_ready_lit", {31'h0, bus_if.ready_o}, 32'h1);
    step("release_rd", 1'b1, 1'b1, 1'b0, 6'd2, 16'h0000);
    check_eq("release_rd_lit", {16'h0, bus_if.rdata_o}, 32'h0);

    // Full sweep: back-to-back writes then back-to-back reads.
    for (int i = 0; i < DEPTH; i++) begin
      sweep_data[i] = WIDTH'($urandom);
      step("sweep_wr", 1'b1, 1'b1, 1'b1, AW'(i), sweep_data[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step("sweep_rd", 1'b1, 1'b1, 1'b0, AW'(i), WIDTH'($urandom));
      check_eq("sweep_lit", {16'h0, bus_if.rdata_o}, {16'h0, sweep_data[i]});
    end

    // Write immediately followed by read of the same address.
    step("hazard_wr", 1'b1, 1'b1, 1'b1, 6'd7, 16'hA5A5);
    step("hazard_rd", 1'b1, 1'b1, 1'b0, 6'd7, 16'h0000);
    check_eq("hazard_lit", {16'h0, bus_if.rdata_o}, 32'hA5A5);

    // Idle hold: request fields toggle with valid low.
    step("idle_wr", 1'b1, 1'b1, 1'b1, 6'd3, 16'h1234);
    step("idle_rd", 1'b1, 1'b1, 1'b0, 6'd3, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      step("idle", 1'b1, 1'b0, 1'($urandom), AW'($urandom), WIDTH'($urandom));
      check_eq("idle_lit", {16'h0, bus_if.rdata_o}, 32'h1234);
    end
    for (int i = 0; i < 3; i++) glitch_step(AW'(3 + i), 16'hDEAD);
    step("idle_chk", 1'b1, 1'b1, 1'b0, 6'd3, 16'h0000);
    check_eq("idle_mem_lit", {16'h0, bus_if.rdata_o}, 32'h1234);

    // Reset in the middle of traffic clears stored data.
    step("midrst_wr", 1'b1, 1'b1, 1'b1, 6'd10, 16'hFFFF);
    step("midrst", 1'b0, 1'b1, 1'b0, 6'd10, 16'h0000);
    step("midrst_rd", 1'b1, 1'b1, 1'b0, 6'd10, 16'h0000);
    step("midrst_rd", 1'b1, 1'b1, 1'b0, 6'd10, 16'h0000);
    check_eq("midrst_lit", {16'h0, bus_if.rdata_o}, 32'h0);

    // A write leaves rdata_o untouched until the next read.
    step("nodist_wr", 1'b1, 1'b1, 1'b1, 6'd5, 16'h00FF);
    step("nodist_rd", 1'b1, 1'b1, 1'b0, 6'd5, 16'h0000);
    step("nodist_wr2", 1'b1, 1'b1, 1'b1, 6'd5, 16'hBEEF);
    check_eq("nodist_hold_lit", {16'h0, bus_if.rdata_o}, 32'h00FF);
    step("nodist_rd2", 1'b1, 1'b1, 1'b0, 6'd5, 16'h0000);
    check_eq("nodist_new_lit", {16'h0, bus_if.rdata_o}, 32'hBEEF);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom), AW'($urandom), WIDTH'($urandom));
    end

    // Final readback of every location against the model.
    step("final_idle", 1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      step("final_rd", 1'b1, 1'b1, 1'b0, AW'(i), 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
